// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock flop-based FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a selectable first-word-fall-through or registered read port.
// All 2**ASIZE entries are usable; flags are decoded from the count register.

module sync_fifo_flex #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = (2 ** ASIZE) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [DSIZE-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [DSIZE-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2 ** ASIZE;

  localparam logic [ASIZE:0] DEPTH_L = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AF_L    = (ASIZE + 1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_L    = (ASIZE + 1)'(AE_THRESH);

  // Elaboration-time legality of the configuration.
  if (DSIZE < 1) begin : g_bad_dsize
    $error("sync_fifo_flex: DSIZE must be >= 1");
  end
  if (ASIZE < 1) begin : g_bad_asize
    $error("sync_fifo_flex: ASIZE must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;

  // Status decode from the registered occupancy only.
  always_comb begin
    full_w       = (count_q == DEPTH_L);
    empty_w      = (count_q == '0);
    full         = full_w;
    empty        = empty_w;
    almost_full  = (count_q >= AF_L);
    almost_empty = (count_q <= AE_L);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // Request qualification, pointer/count and error-flag next state.
  always_comb begin
    wr_acc   = wr_en & ~full_w;
    rd_acc   = rd_en & ~empty_w;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ASIZE'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ASIZE'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ASIZE + 1)'(1);
      2'b01:   count_d = count_q - (ASIZE + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error event in the same cycle as a clear keeps the flag set.
    ovf_d = (wr_en & full_w)  | (ovf_q & ~err_clr);
    unf_d = (rd_en & empty_w) | (unf_q & ~err_clr);
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly from storage.
    assign dout = mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [DSIZE-1:0] dout_q;

    // Registered read port: loads on accepted reads, holds otherwise.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_q[rd_ptr_q];
      end
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Testbench for sync_fifo_flex: three configurations share one stimulus
// stream and are checked every cycle against a queue-based model, plus
// directed literal expectations for the fill/drain, error, threshold,
// registered-read and mid-burst reset scenarios.

module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       wr_en;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] din;

  int checks = 0;
  int errors = 0;

  // Lane 0: ASIZE=2 FWFT; lane 1: ASIZE=3 FWFT AF=6 AE=1; lane 2: ASIZE=2 registered.
  localparam int DEP [3] = '{4, 8, 4};
  localparam int AFT [3] = '{2, 6, 2};
  localparam int AET [3] = '{2, 1, 2};
  localparam int FW  [3] = '{1, 1, 0};

  logic [7:0] dq  [3];
  logic       fl  [3];
  logic       em  [3];
  logic       afl [3];
  logic       aem [3];
  logic       ov  [3];
  logic       un  [3];
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;
  logic [2:0] cnt_c;
  logic [3:0] cnt [3];

  assign cnt[0] = {1'b0, cnt_a};
  assign cnt[1] = cnt_b;
  assign cnt[2] = {1'b0, cnt_c};

  sync_fifo_flex #(.DSIZE(8), .ASIZE(2), .FWFT(1)) u_a (
    .clk(clk), .rst_b(rst_b), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dq[0]), .full(fl[0]), .empty(em[0]),
    .almost_full(afl[0]), .almost_empty(aem[0]), .count(cnt_a),
    .overflow(ov[0]), .underflow(un[0])
  );

  sync_fifo_flex #(.DSIZE(8), .ASIZE(3), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_b (
    .clk(clk), .rst_b(rst_b), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dq[1]), .full(fl[1]), .empty(em[1]),
    .almost_full(afl[1]), .almost_empty(aem[1]), .count(cnt_b),
    .overflow(ov[1]), .underflow(un[1])
  );

  sync_fifo_flex #(.DSIZE(8), .ASIZE(2), .FWFT(0)) u_c (
    .clk(clk), .rst_b(rst_b), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dq[2]), .full(fl[2]), .empty(em[2]),
    .almost_full(afl[2]), .almost_empty(aem[2]), .count(cnt_c),
    .overflow(ov[2]), .underflow(un[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words per lane.
  logic [7:0] mq [3][$];
  int         mcnt [3];
  logic       movf [3];
  logic       munf [3];
  logic [7:0] mdreg [3];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        mcnt[i]  <= 0;
        movf[i]  <= 1'b0;
        munf[i]  <= 1'b0;
        mdreg[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rd_en && mcnt[i] != 0) begin
          mdreg[i] <= mq[i].pop_front();
        end
        if (wr_en && mcnt[i] != DEP[i]) begin
          mq[i].push_back(din);
        end
        mcnt[i] <= mcnt[i] + ((wr_en && mcnt[i] != DEP[i]) ? 1 : 0)
                           - ((rd_en && mcnt[i] != 0) ? 1 : 0);
        movf[i] <= (wr_en && mcnt[i] == DEP[i]) ? 1'b1 : (err_clr ? 1'b0 : movf[i]);
        munf[i] <= (rd_en && mcnt[i] == 0)      ? 1'b1 : (err_clr ? 1'b0 : munf[i]);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("l%0d_count", i), 32'(cnt[i]), 32'(mcnt[i]));
      chk($sformatf("l%0d_full", i),  32'(fl[i]),  32'(mcnt[i] == DEP[i]));
      chk($sformatf("l%0d_empty", i), 32'(em[i]),  32'(mcnt[i] == 0));
      chk($sformatf("l%0d_afull", i), 32'(afl[i]), 32'(mcnt[i] >= AFT[i]));
      chk($sformatf("l%0d_aempty", i), 32'(aem[i]), 32'(mcnt[i] <= AET[i]));
      chk($sformatf("l%0d_ovf", i),   32'(ov[i]),  32'(movf[i]));
      chk($sformatf("l%0d_unf", i),   32'(un[i]),  32'(munf[i]));
      if (FW[i] != 0) begin
        if (mcnt[i] != 0) chk($sformatf("l%0d_dout", i), 32'(dq[i]), 32'(mq[i][0]));
      end else begin
        chk($sformatf("l%0d_dout", i), 32'(dq[i]), 32'(mdreg[i]));
      end
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_en   = w;
    rd_en   = r;
    din     = d;
    err_clr = c;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_v [4];
  logic [7:0] exp_v;
  int         wp;

  initial begin
    fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_b = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_empty", 32'(em[0]), 1);
    chk("rst_full", 32'(fl[0]), 0);
    chk("rst_aempty", 32'(aem[0]), 1);
    chk("rst_afull", 32'(afl[0]), 0);
    chk("rst_ovf", 32'(ov[0]), 0);
    chk("rst_dout_reg", 32'(dq[2]), 0);
    rst_b = 1'b1;

    // Fill and drain.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, fill_v[k], 1'b0);
      chk("fill_count", 32'(cnt_a), 32'(k + 1));
      if (k == 0) chk("fwft_first", 32'(dq[0]), 32'h11);
    end
    chk("fill_full", 32'(fl[0]), 1);

    // Overflow, clear, and set-beats-clear.
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    chk("ovf_count", 32'(cnt_a), 4);
    chk("ovf_set", 32'(ov[0]), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(ov[0]), 0);
    cyc(1'b1, 1'b0, 8'h56, 1'b1);
    chk("ovf_set_wins", 32'(ov[0]), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    for (int k = 0; k < 4; k++) begin
      chk("drain_fwft", 32'(dq[0]), 32'(fill_v[k]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_reg", 32'(dq[2]), 32'(fill_v[k]));
    end
    chk("drain_empty", 32'(em[0]), 1);
    chk("drain_count", 32'(cnt_a), 0);

    // Simultaneous ops at empty: write only.
    cyc(1'b1, 1'b1, 8'h66, 1'b0);
    chk("empty_rw_count", 32'(cnt_a), 1);
    chk("empty_rw_unf", 32'(un[0]), 1);
    chk("reg_hold", 32'(dq[2]), 32'h44);
    chk("reg_unf", 32'(un[2]), 1);
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    chk("two_count", 32'(cnt_a), 2);

    // Steady-state streaming across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      exp_v = (k == 0) ? 8'h66 : (k == 1) ? 8'h77 : 8'(8'h80 + k - 2);
      chk("stream_dout", 32'(dq[0]), 32'(exp_v));
      cyc(1'b1, 1'b1, 8'(8'h80 + k), 1'b0);
      chk("stream_count", 32'(cnt_a), 2);
    end

    // Simultaneous ops at full: read only.
    cyc(1'b1, 1'b0, 8'hA0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA1, 1'b0);
    chk("refill_full", 32'(fl[0]), 1);
    cyc(1'b1, 1'b1, 8'hA2, 1'b0);
    chk("full_rw_count", 32'(cnt_a), 3);
    chk("full_rw_ovf", 32'(ov[0]), 1);

    // Registered read timing and hold on rejected read.
    do_reset();
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("reg_before_read", 32'(dq[2]), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("reg_after_read", 32'(dq[2]), 32'hA5);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("reg_reject_hold", 32'(dq[2]), 32'hA5);
    chk("reg_reject_unf", 32'(un[2]), 1);

    // Threshold sweep on the ASIZE=3 lane.
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) cyc(1'b1, 1'b0, 8'(k), 1'b0);
      chk("thr_count", 32'(cnt_b), 32'(k));
      chk("thr_aempty", 32'(aem[1]), 32'(k <= 1));
      chk("thr_afull", 32'(afl[1]), 32'(k >= 6));
      chk("thr_full", 32'(fl[1]), 32'(k == 8));
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'hC0 + k), 1'b0);
    chk("burst_count", 32'(cnt_b), 5);
    chk("burst_ovf", 32'(ov[0]), 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_count", 32'(cnt_b), 0);
    chk("async_empty", 32'(em[1]), 1);
    chk("async_aempty", 32'(aem[1]), 1);
    chk("async_ovf", 32'(ov[0]), 0);
    chk("async_count_a", 32'(cnt_a), 0);
    #2;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 8'h7E, 1'b0);
    chk("post_rst_a", 32'(dq[0]), 32'h7E);
    chk("post_rst_b", 32'(dq[1]), 32'h7E);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_c", 32'(dq[2]), 32'h7E);

    // Randomized traffic with alternating fill/drain bias.
    for (int n = 0; n < 3000; n++) begin
      wp = ((n / 150) % 2 == 0) ? 70 : 30;
      if (n == 1500) do_reset();
      cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
          8'($urandom), $urandom_range(0, 24) == 0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised successor to the team's single-clock flop-based FIFO.
- Adds an explicit occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Output mode is selectable: first-word-fall-through (FWFT) or registered standard read.
- Drop-in buffer between single-clock producer/consumer pipelines; all 2**ASIZE entries usable.

Parameters:
- DSIZE, 8, data width in bits (>=1).
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries (ASIZE >= 1).
- FWFT, 1, 1 = head word visible on dout while !empty; 0 = dout registered, updated the cycle after an accepted read.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (range 0..DEPTH-1).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- din  input  DSIZE  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- err_clr  input  1  synchronous clear of overflow/underflow.
- dout  output  DSIZE  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_b is asynchronous and active-low.
- Reset (async assert, sync to clk on release):
  - rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0.
  - almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0), i.e. 0 for any legal AF_THRESH.
  - overflow = underflow = 0; registered dout = 0 (FWFT = 0).
  - Storage array is not reset.
- Qualifiers: wr_acc = wr_en & !full; rd_acc = rd_en & !empty. Both use the registered full/empty of the current cycle.
  - A write while full is dropped even if rd_en is high the same cycle.
  - A read while empty is dropped even if wr_en is high the same cycle.
- Pointers: ASIZE bits, +1 per accepted op, natural wrap at DEPTH-1 -> 0. Write stores din at wr_ptr on the clk edge.
- count (registered):
  - +1 on wr_acc & !rd_acc; -1 on rd_acc & !wr_acc; unchanged on both or neither.
- Flags:
  - full, empty, almost_full, almost_empty are decoded from the count register only, never from the inputs. They update in the same cycle count updates; no combinational input-to-flag path.
- Both accepted at the same time (0 < count < DEPTH): data enters and leaves; count and flags unchanged.
- FWFT = 1:
  - dout = mem[rd_ptr] combinationally from storage registers; valid whenever empty = 0.
  - A write into an empty FIFO appears on dout at edge+1, the same cycle empty falls.
  - rd_acc advances to the next word at the next edge.
- FWFT = 0:
  - On rd_acc, dout <= mem[rd_ptr] at the edge; data is valid the cycle after the read.
  - dout holds its value otherwise, including during rejected reads.
- Errors:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty. Both are sticky.
  - err_clr clears both at the next edge. If set and clear occur in the same cycle, set wins.
  - Error events never alter pointers, count, or storage.
- Mid-operation reset: all state returns to reset values immediately; stored data is treated as discarded.
- Threshold legality is checked by an elaboration-time assertion (AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1).

Test Plan:
- Fill/drain (DSIZE=8, ASIZE=2, FWFT=1):
  - Write 0x11,0x22,0x33,0x44 -> count 1..4; full=1 after the 4th edge.
  - Read 4 -> dout 0x11,0x22,0x33,0x44 in order; empty=1; count=0.
- Overflow/err_clr:
  - At full, assert wr_en with din=0x55 -> count stays 4, overflow=1, and the stored data does not contain 0x55.
  - Pulse err_clr -> overflow=0 next cycle.
  - With wr_en&full and err_clr in the same cycle -> overflow stays 1.
- Simultaneous ops:
  - At count=2, wr_en=rd_en=1 for 10 cycles with incrementing data -> count constant at 2, output order preserved across pointer wrap.
  - At full, wr_en=rd_en=1 -> read only, count 3.
  - At empty, wr_en=rd_en=1 -> write only, count 1, underflow=1.
- Thresholds (ASIZE=3, AF_THRESH=6, AE_THRESH=1):
  - Step count 0->8 -> almost_empty high for counts 0-1; almost_full high for counts 6-8.
- Registered mode (FWFT=0):
  - Write 0xA5, read it -> dout=0xA5 exactly one cycle after rd_acc.
  - Rejected read on empty -> dout held at 0xA5, underflow=1.
- Reset mid-burst:
  - Assert rst_b low asynchronously (between edges) at count=5 -> count=0, empty=1, flags cleared immediately.
  - After release, first write of 0x7E reads back as 0x7E.
